int_controller: RTL and testbench
=================================

// Module: int_controller
// PURPOSE
//  Interrupt controller directly upstream of the Gumnut core's int_req/int_ack handshake.
//  Synchronises N_SRC external interrupt lines and latches their rising edges as pending bits.
//  Masks and prioritises the pending sources and drives a single request to the core.
//  Exposes MASK/PEND/CAUSE/CTRL registers on the core's I/O port bus (Wishbone-style, single-cycle ack).
// PARAMETERS
//  N_SRC      8      number of interrupt sources, 1..8; index 0 = highest priority
//  PORT_BASE  8'hF0  I/O base address; registers at PORT_BASE+0..3, PORT_BASE[1:0] must be 0
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  cen         in   1      clock enable; every register updates only when cen=1
//  irq_src_i   in   N_SRC  asynchronous interrupt lines, rising-edge sensitive
//  port_cyc_i  in   1      I/O bus cycle
//  port_stb_i  in   1      I/O bus strobe
//  port_we_i   in   1      I/O write (1) / read (0)
//  port_adr_i  in   8      I/O address
//  port_dat_i  in   8      I/O write data
//  port_dat_o  out  8      I/O read data; valid only while port_ack_o=1, else 8'h00
//  port_ack_o  out  1      I/O acknowledge, one-cycle pulse
//  int_req_o   out  1      interrupt request to core, registered
//  int_ack_i   in   1      core acknowledge, one-cycle pulse when the core vectors
// BEHAVIOUR
//  Reset: all flops 0; MASK=0, PEND=0, CAUSE=0, CTRL=0, FSM=IDLE; int_req_o, port_ack_o, port_dat_o = 0.
//   Reset mid-operation clears everything at once; an in-flight bus access gets no ack.
//  Sync: 2-flop synchroniser plus a prev flop per source; edge = s2 & ~prev sets PEND[i] one cycle later.
//   Flops reset to 0, so a line held high through reset records exactly one edge.
//  Registers, offset from PORT_BASE:
//   +0 MASK  R/W, bit i=1 enables source i; bits >= N_SRC read 0.
//   +1 PEND  R; a write clears every bit written as 1 (W1C).
//   +2 CAUSE R; [2:0] = serviced index, [7] = valid; any write = EOI.
//   +3 CTRL  R/W; [0] = global enable GE; other bits read 0.
//  Bus: on cycle T, cyc&stb&adr in range -> port_ack_o=1 at T+1, port_dat_o = register value at T.
//   Write takes effect at T+1. Out-of-range address: no ack, no effect (other slaves decode it).
//   Back-to-back strobes are acked every cycle.
//  act = GE & |(PEND & MASK).
//  FSM:
//   IDLE: int_req_o=0. If act -> REQ.
//   REQ: int_req_o=1. int_ack_i -> SERVICE; lowest i of PEND&MASK goes to CAUSE={1,0000,i[2:0]};
//    PEND[i] cleared. !act with no ack (mask, GE or W1C dropped) -> IDLE, request withdrawn.
//   SERVICE: int_req_o=0; no nesting. EOI write -> IDLE, CAUSE[7] cleared, CAUSE[2:0] held.
//  int_req_o is a registered decode of state: asserts the cycle after entering REQ.
//   It drops the cycle after ack.
//  Simultaneous events:
//   edge set and W1C on the same bit -> set wins.
//   ack and W1C in the same cycle -> CAUSE selected from pre-write PEND.
//   edge on a source while it is being acked -> bit stays pending.
//   int_ack_i in IDLE or SERVICE -> ignored; CAUSE unchanged.
//   EOI in IDLE/REQ -> ignored.
//  cen=0: all state, sync flops and port_ack_o hold.
//   Edges occurring only while cen=0 may be lost.
// STRUCTURE
//  int_ctrl_pkg: state_t enum {IDLE, REQ, SERVICE}, REG_MASK/REG_PEND/REG_CAUSE/REG_CTRL offset localparams,
//   CAUSE_VALID bit index.
//  Sub-module int_edge_sync: one source; synchroniser + edge detect; clk/rst/cen/a_i -> edge_o.
//   Instantiated N_SRC times in a generate loop.
//  Top holds the registers, priority encoder, FSM and bus decode.
// TESTING
//  1. Reset, write MASK=8'h05, CTRL=1, pulse irq_src_i[2].
//   -> PEND=8'h04; int_req_o=1 by the 4th cycle after the edge.
//   Ack -> CAUSE=8'h82, PEND=0, int_req_o=0 next cycle.
//  2. Edges on 5 and 1 together, MASK=FF, GE=1.
//   -> first ack CAUSE=8'h81; EOI -> REQ again; second ack CAUSE=8'h85.
//  3. Pending src 3, MASK=0 -> int_req_o stays 0.
//   Set MASK[3] -> request. Clear GE while in REQ -> int_req_o=0 next cycle, PEND[3] still 1.
//  4. W1C PEND=08 in the same cycle as a new edge on src 3 -> PEND[3]=1.
//   Ack and W1C together -> CAUSE from pre-write PEND.
//  5. Read at PORT_BASE+4 -> no ack. Reads of +0..+3 back-to-back -> four consecutive acks with correct data.
//   int_ack_i in IDLE -> CAUSE unchanged.
//  6. Assert rst low mid-REQ with a read strobe pending.
//   -> int_req_o, port_ack_o, MASK, PEND, CAUSE all 0 immediately. Hold cen=0: state frozen.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared types and register map for the interrupt controller.
package int_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_CAUSE = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CAUSE_VALID = 7;

endpackage

// File: rtl/int_edge_sync.sv
// Two-flop synchroniser plus rising-edge detect for a single interrupt line.
module int_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic a_i,
    output logic edge_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;

    // prev_q resets to 0, so a line already high at reset yields one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else if (cen) begin
            s1_q   <= a_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign edge_o = s2_q & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: edge-latched pending bits, mask/priority, request FSM
// towards the core and a small register file on the I/O port bus.
module int_controller
    import int_ctrl_pkg::*;
#(
    parameter int         N_SRC     = 8,
    parameter logic [7:0] PORT_BASE = 8'hF0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [N_SRC-1:0] irq_src_i,
    input  logic             port_cyc_i,
    input  logic             port_stb_i,
    input  logic             port_we_i,
    input  logic [7:0]       port_adr_i,
    input  logic [7:0]       port_dat_i,
    output logic [7:0]       port_dat_o,
    output logic             port_ack_o,
    output logic             int_req_o,
    input  logic             int_ack_i
);

    logic [N_SRC-1:0] edgeVec;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] pendMasked;
    logic [N_SRC-1:0] selOneHot;
    logic [2:0]       selIdx;
    logic [2:0]       causeIdx_q, causeIdx_d;
    logic             causeValid_q, causeValid_d;
    logic             ctrlGe_q, ctrlGe_d;
    state_t           state_q, state_d;
    logic             req_q;
    logic             ack_q;
    logic [7:0]       dat_q;
    logic [7:0]       rdData;
    logic [7:0]       maskExt;
    logic [7:0]       pendExt;
    logic             hit;
    logic             wrMask, wrPend, wrCause, wrCtrl;
    logic             act;

    for (genvar g = 0; g < N_SRC; g++) begin : gSrc
        int_edge_sync uSync (
            .clk    (clk),
            .rst    (rst),
            .cen    (cen),
            .a_i    (irq_src_i[g]),
            .edge_o (edgeVec[g])
        );
    end

    assign hit     = port_cyc_i & port_stb_i & (port_adr_i[7:2] == PORT_BASE[7:2]);
    assign wrMask  = hit & port_we_i & (port_adr_i[1:0] == REG_MASK);
    assign wrPend  = hit & port_we_i & (port_adr_i[1:0] == REG_PEND);
    assign wrCause = hit & port_we_i & (port_adr_i[1:0] == REG_CAUSE);
    assign wrCtrl  = hit & port_we_i & (port_adr_i[1:0] == REG_CTRL);

    assign pendMasked = pend_q & mask_q;
    assign act        = ctrlGe_q & (|pendMasked);

    // Scan from the top so the lowest set index is the one left standing.
    always_comb begin
        selIdx    = 3'd0;
        selOneHot = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (pendMasked[i]) begin
                selIdx       = 3'(i);
                selOneHot    = '0;
                selOneHot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        maskExt                = 8'h00;
        maskExt[N_SRC-1:0]     = mask_q;
        pendExt                = 8'h00;
        pendExt[N_SRC-1:0]     = pend_q;
        rdData                 = 8'h00;
        case (port_adr_i[1:0])
            REG_MASK:  rdData = maskExt;
            REG_PEND:  rdData = pendExt;
            REG_CAUSE: begin
                rdData[CAUSE_VALID] = causeValid_q;
                rdData[2:0]         = causeIdx_q;
            end
            REG_CTRL:  rdData[0] = ctrlGe_q;
        endcase
    end

    // Edges are ORed in last so a new edge beats both W1C and the ack clear.
    always_comb begin
        mask_d       = mask_q;
        pend_d       = pend_q;
        ctrlGe_d     = ctrlGe_q;
        causeIdx_d   = causeIdx_q;
        causeValid_d = causeValid_q;
        state_d      = state_q;

        if (wrMask) mask_d   = port_dat_i[N_SRC-1:0];
        if (wrCtrl) ctrlGe_d = port_dat_i[0];
        if (wrPend) pend_d   = pend_d & ~port_dat_i[N_SRC-1:0];

        case (state_q)
            IDLE: begin
                if (act) state_d = REQ;
            end
            REQ: begin
                if (int_ack_i && act) begin
                    state_d      = SERVICE;
                    causeValid_d = 1'b1;
                    causeIdx_d   = selIdx;
                    pend_d       = pend_d & ~selOneHot;
                end else if (!act) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (wrCause) begin
                    state_d      = IDLE;
                    causeValid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        pend_d = pend_d | edgeVec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q       <= '0;
            pend_q       <= '0;
            ctrlGe_q     <= 1'b0;
            causeIdx_q   <= 3'd0;
            causeValid_q <= 1'b0;
            state_q      <= IDLE;
            req_q        <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= 8'h00;
        end else if (cen) begin
            mask_q       <= mask_d;
            pend_q       <= pend_d;
            ctrlGe_q     <= ctrlGe_d;
            causeIdx_q   <= causeIdx_d;
            causeValid_q <= causeValid_d;
            state_q      <= state_d;
            req_q        <= (state_d == REQ);
            ack_q        <= hit;
            dat_q        <= hit ? rdData : 8'h00;
        end
    end

    assign int_req_o  = req_q;
    assign port_ack_o = ack_q;
    assign port_dat_o = dat_q;

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: bus reads are scoreboarded and
// checked when the ack arrives; FSM corner cases use hand-written sequences.
module tb_int_controller;

    localparam int N_SRC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cen = 1'b1;
    logic [7:0] irqSrc = 8'h00;
    logic       cyc = 1'b0;
    logic       stb = 1'b0;
    logic       we = 1'b0;
    logic [7:0] adr = 8'h00;
    logic [7:0] datIn = 8'h00;
    logic [7:0] datOut;
    logic       ack;
    logic       intReq;
    logic       intAck = 1'b0;

    int_controller #(.N_SRC(N_SRC), .PORT_BASE(8'hF0)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .irq_src_i  (irqSrc),
        .port_cyc_i (cyc),
        .port_stb_i (stb),
        .port_we_i  (we),
        .port_adr_i (adr),
        .port_dat_i (datIn),
        .port_dat_o (datOut),
        .port_ack_o (ack),
        .int_req_o  (intReq),
        .int_ack_i  (intAck)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         isRead;
        logic [7:0] data;
        int         due;
    } sbEntry_t;

    typedef struct {
        logic       we;
        logic [7:0] adr;
        logic [7:0] dat;
        logic       expAck;
        logic [7:0] expDat;
        string      name;
    } busVec_t;

    sbEntry_t sbQ[$];
    sbEntry_t e;
    busVec_t  vecs[$];
    int       tests = 0;
    int       fails = 0;
    int       cycleCnt = 0;
    bit       monOn = 1'b1;

    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
        end
    endtask

    // Acks are matched in order against what the stimulus side queued.
    always @(negedge clk) begin
        if (rst && monOn) begin
            if (ack) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected ack", {7'b0, ack}, 8'h00);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.name, " ack timing"}, 8'(cycleCnt - e.due), 8'h00);
                    if (e.isRead) checkOutput(e.name, datOut, e.data);
                end
            end else if (sbQ.size() > 0 && sbQ[0].due <= cycleCnt) begin
                e = sbQ.pop_front();
                checkOutput({e.name, " ack"}, {7'b0, ack}, 8'h01);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busDrive(input logic w, input logic [7:0] a, input logic [7:0] d,
                            input logic expAck, input logic [7:0] expDat, input string name);
        sbEntry_t s;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = w;
        adr   = a;
        datIn = d;
        if (expAck) begin
            s.name   = name;
            s.isRead = !w;
            s.data   = expDat;
            s.due    = cycleCnt + 1;
            sbQ.push_back(s);
        end
    endtask

    task automatic busIdle();
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        datIn = 8'h00;
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                                 input logic expAck, input logic [7:0] expDat, input string name);
        busDrive(w, a, d, expAck, expDat, name);
        tick();
        busIdle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input string name);
        applyStimulus(1'b1, a, d, 1'b1, 8'h00, name);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] expDat, input string name);
        applyStimulus(1'b0, a, 8'h00, 1'b1, expDat, name);
    endtask

    task automatic waitReq(input logic want, input int budget, input string name);
        int n = 0;
        while (intReq !== want && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, {7'b0, intReq}, {7'b0, want});
    endtask

    task automatic pulse(input int idx);
        irqSrc[idx] = 1'b1;
        tick();
        tick();
        irqSrc[idx] = 1'b0;
    endtask

    task automatic ackPulse();
        intAck = 1'b1;
        tick();
        intAck = 1'b0;
    endtask

    function automatic busVec_t mkVec(input logic w, input logic [7:0] a, input logic [7:0] d,
                                      input logic expAck, input logic [7:0] expDat, input string name);
        busVec_t v;
        v.we = w; v.adr = a; v.dat = d; v.expAck = expAck; v.expDat = expDat; v.name = name;
        return v;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        tick();
        checkOutput("reset int_req", {7'b0, intReq}, 8'h00);
        checkOutput("reset ack", {7'b0, ack}, 8'h00);
        checkOutput("reset dat", datOut, 8'h00);
        rst = 1'b1;
        tick();

        // Single source through the full handshake
        wr(8'hF0, 8'h05, "t1 wr mask");
        wr(8'hF3, 8'h01, "t1 wr ctrl");
        pulse(2);
        waitReq(1'b1, 2, "t1 req by 4th cycle");
        rd(8'hF1, 8'h04, "t1 pend");
        ackPulse();
        checkOutput("t1 req drop", {7'b0, intReq}, 8'h00);
        rd(8'hF2, 8'h82, "t1 cause");
        rd(8'hF1, 8'h00, "t1 pend cleared");
        wr(8'hF2, 8'h00, "t1 eoi");
        rd(8'hF2, 8'h02, "t1 cause after eoi");

        // Two sources, priority and no nesting
        wr(8'hF0, 8'hFF, "t2 wr mask");
        irqSrc[5] = 1'b1;
        irqSrc[1] = 1'b1;
        tick();
        tick();
        irqSrc = 8'h00;
        waitReq(1'b1, 6, "t2 req");
        ackPulse();
        rd(8'hF2, 8'h81, "t2 cause first");
        rd(8'hF1, 8'h20, "t2 pend after first");
        tick();
        checkOutput("t2 no nesting", {7'b0, intReq}, 8'h00);
        wr(8'hF2, 8'h00, "t2 eoi1");
        waitReq(1'b1, 6, "t2 req again");
        ackPulse();
        rd(8'hF2, 8'h85, "t2 cause second");
        wr(8'hF2, 8'h00, "t2 eoi2");

        // Masking and global enable
        wr(8'hF0, 8'h00, "t3 mask off");
        pulse(3);
        repeat (4) tick();
        checkOutput("t3 masked no req", {7'b0, intReq}, 8'h00);
        rd(8'hF1, 8'h08, "t3 pend");
        wr(8'hF0, 8'h08, "t3 mask on");
        waitReq(1'b1, 6, "t3 req");
        wr(8'hF3, 8'h00, "t3 ge off");
        tick();
        checkOutput("t3 ge drop", {7'b0, intReq}, 8'h00);
        rd(8'hF1, 8'h08, "t3 pend kept");
        wr(8'hF3, 8'h01, "t3 ge on");
        waitReq(1'b1, 6, "t3 req back");

        // W1C racing an edge, then ack racing a W1C
        irqSrc[3] = 1'b1;
        tick();
        tick();
        busDrive(1'b1, 8'hF1, 8'h08, 1'b1, 8'h00, "t4 w1c vs edge");
        tick();
        busIdle();
        irqSrc[3] = 1'b0;
        rd(8'hF1, 8'h08, "t4 set wins");
        checkOutput("t4 req held", {7'b0, intReq}, 8'h01);
        wr(8'hF0, 8'hFF, "t4 mask all");
        pulse(1);
        tick();
        tick();
        busDrive(1'b1, 8'hF1, 8'h02, 1'b1, 8'h00, "t4 w1c with ack");
        intAck = 1'b1;
        tick();
        busIdle();
        intAck = 1'b0;
        rd(8'hF2, 8'h81, "t4 cause pre-write");
        rd(8'hF1, 8'h08, "t4 pend after");
        wr(8'hF2, 8'h00, "t4 eoi1");
        waitReq(1'b1, 6, "t4 req src3");
        ackPulse();
        rd(8'hF2, 8'h83, "t4 cause src3");
        wr(8'hF2, 8'h00, "t4 eoi2");

        // Address decode and back-to-back accesses from a table
        vecs.push_back(mkVec(1'b0, 8'hF4, 8'h00, 1'b0, 8'h00, "t5 rd F4"));
        vecs.push_back(mkVec(1'b1, 8'hF4, 8'h00, 1'b0, 8'h00, "t5 wr F4"));
        vecs.push_back(mkVec(1'b0, 8'hEF, 8'h00, 1'b0, 8'h00, "t5 rd EF"));
        vecs.push_back(mkVec(1'b0, 8'hF0, 8'h00, 1'b1, 8'hFF, "t5 rd mask"));
        vecs.push_back(mkVec(1'b0, 8'hF1, 8'h00, 1'b1, 8'h00, "t5 rd pend"));
        vecs.push_back(mkVec(1'b0, 8'hF2, 8'h00, 1'b1, 8'h03, "t5 rd cause"));
        vecs.push_back(mkVec(1'b0, 8'hF3, 8'h00, 1'b1, 8'h01, "t5 rd ctrl"));
        vecs.push_back(mkVec(1'b1, 8'hF0, 8'h5A, 1'b1, 8'h00, "t5 wr mask"));
        vecs.push_back(mkVec(1'b0, 8'hF0, 8'h00, 1'b1, 8'h5A, "t5 rd mask 5A"));
        vecs.push_back(mkVec(1'b1, 8'hF3, 8'hFE, 1'b1, 8'h00, "t5 wr ctrl FE"));
        vecs.push_back(mkVec(1'b0, 8'hF3, 8'h00, 1'b1, 8'h00, "t5 rd ctrl 00"));
        vecs.push_back(mkVec(1'b1, 8'hF3, 8'h01, 1'b1, 8'h00, "t5 wr ctrl 01"));
        vecs.push_back(mkVec(1'b0, 8'hF3, 8'h00, 1'b1, 8'h01, "t5 rd ctrl 01"));
        foreach (vecs[i]) begin
            busDrive(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].expAck, vecs[i].expDat, vecs[i].name);
            tick();
        end
        busIdle();
        tick();
        applyStimulus(1'b0, 8'hF5, 8'h00, 1'b0, 8'h00, "t5 rd F5");
        checkOutput("t5 no ack F5", {7'b0, ack}, 8'h00);
        ackPulse();
        rd(8'hF2, 8'h03, "t5 ack in idle");
        checkOutput("t5 idle no req", {7'b0, intReq}, 8'h00);

        // Reset mid-request with a read in flight
        pulse(4);
        waitReq(1'b1, 6, "t6 req");
        busDrive(1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, "t6 inflight");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t6 reset req", {7'b0, intReq}, 8'h00);
        checkOutput("t6 reset ack", {7'b0, ack}, 8'h00);
        checkOutput("t6 reset dat", datOut, 8'h00);
        busIdle();
        tick();
        checkOutput("t6 no late ack", {7'b0, ack}, 8'h00);
        cen = 1'b0;
        rst = 1'b1;
        busDrive(1'b1, 8'hF0, 8'hFF, 1'b0, 8'h00, "t6 frozen wr");
        irqSrc[0] = 1'b1;
        repeat (3) tick();
        checkOutput("t6 frozen ack", {7'b0, ack}, 8'h00);
        checkOutput("t6 frozen req", {7'b0, intReq}, 8'h00);
        irqSrc[0] = 1'b0;
        busIdle();
        tick();
        cen = 1'b1;
        repeat (3) tick();
        rd(8'hF0, 8'h00, "t6 mask after reset");
        rd(8'hF1, 8'h00, "t6 pend after reset");
        rd(8'hF2, 8'h00, "t6 cause after reset");
        rd(8'hF3, 8'h00, "t6 ctrl after reset");

        // port_ack_o and read data hold while cen is low
        wr(8'hF0, 8'h3C, "t6 wr mask 3C");
        tick();
        monOn = 1'b0;
        busDrive(1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, "t6 held rd");
        tick();
        busIdle();
        cen = 1'b0;
        tick();
        tick();
        checkOutput("t6 ack held", {7'b0, ack}, 8'h01);
        checkOutput("t6 dat held", datOut, 8'h3C);
        cen = 1'b1;
        tick();
        checkOutput("t6 ack released", {7'b0, ack}, 8'h00);
        monOn = 1'b1;

        // A line held high through reset records exactly one edge
        irqSrc[6] = 1'b1;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        repeat (4) tick();
        rd(8'hF1, 8'h40, "t7 edge through reset");
        wr(8'hF1, 8'h40, "t7 w1c");
        repeat (3) tick();
        rd(8'hF1, 8'h00, "t7 single edge");
        irqSrc[6] = 1'b0;

        repeat (3) tick();
        checkOutput("scoreboard drained", 8'(sbQ.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
